// File: rtl/weight_loader_pkg.sv
// -----------------------------------------------------------------------------
// weight_loader_pkg
// Shared types and helpers for weight_stream_loader:
//   - wl_state_t : loader FSM state encoding
//   - wl_tag_t   : destination tag carried alongside each ROM read
//   - layer_in / layer_out / layer_words / layer_base : layer geometry derived
//     from packed per-layer channel counts (8 bits per layer, layer k at
//     [8k+7:8k])
//   - TOTAL_WORDS : ROM size for the default six-layer network
// -----------------------------------------------------------------------------
package weight_loader_pkg;

    localparam int MAX_LAYERS = 8;            // layer index is at most 3 bits
    localparam int PW         = 8 * MAX_LAYERS;
    localparam int KTAPS      = 9;            // 3x3 kernel

    localparam int              DEF_NUM_LAYERS = 6;
    localparam logic [PW-1:0]   DEF_IN_CH  = {8'd0, 8'd0, 8'd9, 8'd9, 8'd9, 8'd9, 8'd3, 8'd3};
    localparam logic [PW-1:0]   DEF_OUT_CH = {8'd0, 8'd0, 8'd3, 8'd9, 8'd9, 8'd9, 8'd9, 8'd12};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } wl_state_t;

    typedef struct packed {
        logic       is_bias;
        logic [2:0] layer;
        logic [7:0] out_ch;
        logic [7:0] in_ch;
        logic [3:0] tap;
    } wl_tag_t;

    function automatic int layer_in(input int k, input logic [PW-1:0] in_ch);
        return int'(in_ch[8*k +: 8]);
    endfunction

    function automatic int layer_out(input int k, input logic [PW-1:0] out_ch);
        return int'(out_ch[8*k +: 8]);
    endfunction

    // Weights (IN*OUT*9) followed by one bias per output channel.
    function automatic int layer_words(input int k, input logic [PW-1:0] in_ch,
                                       input logic [PW-1:0] out_ch);
        return layer_in(k, in_ch) * layer_out(k, out_ch) * KTAPS + layer_out(k, out_ch);
    endfunction

    // Layers are packed back to back in ROM, so the base is a prefix sum.
    function automatic int layer_base(input int k, input logic [PW-1:0] in_ch,
                                      input logic [PW-1:0] out_ch);
        int sum;
        sum = 0;
        for (int j = 0; j < MAX_LAYERS; j++) begin
            if (j < k) sum += layer_words(j, in_ch, out_ch);
        end
        return sum;
    endfunction

    localparam int TOTAL_WORDS = layer_base(DEF_NUM_LAYERS, DEF_IN_CH, DEF_OUT_CH);

endpackage

// File: rtl/weight_stream_loader_if.sv
// -----------------------------------------------------------------------------
// weight_stream_loader_if
// Bus bundle between the loader, the weight ROM and the layer weight RAMs.
//   ROM side  : rom_en, rom_addr (loader -> ROM), rom_data (ROM -> loader)
//   Write side: wr_valid, wr_is_bias, wr_layer, wr_out_ch, wr_in_ch, wr_tap,
//               wr_data (loader -> RAMs), wr_ready (RAMs -> loader)
// master = loader, slave = ROM / RAM environment.
// -----------------------------------------------------------------------------
interface weight_stream_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LW         = 3
);
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  wr_is_bias;
    logic [LW-1:0]         wr_layer;
    logic [7:0]            wr_out_ch;
    logic [7:0]            wr_in_ch;
    logic [3:0]            wr_tap;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output rom_en, rom_addr,
        input  rom_data,
        output wr_valid, wr_is_bias, wr_layer, wr_out_ch, wr_in_ch, wr_tap, wr_data,
        input  wr_ready
    );

    modport slave (
        input  rom_en, rom_addr,
        output rom_data,
        input  wr_valid, wr_is_bias, wr_layer, wr_out_ch, wr_in_ch, wr_tap, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/wl_return_fifo.sv
// -----------------------------------------------------------------------------
// wl_return_fifo
// Small synchronous FIFO holding returned ROM words with their tags.
//   clk, reset (async, active-low)
//   push, push_data : write side (caller guarantees no push when full)
//   pop             : read side (caller guarantees no pop when empty)
//   head_data       : entry at the head, valid while head_valid=1
//   count           : current occupancy
// -----------------------------------------------------------------------------
module wl_return_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Depth is generally not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= bump(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= bump(rd_ptr_reg);
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= push_data;
    end

    assign head_data  = mem[rd_ptr_reg];
    assign head_valid = (count_reg != '0);
    assign count      = count_reg;
endmodule

// File: rtl/weight_stream_loader.sv
// -----------------------------------------------------------------------------
// weight_stream_loader
// Streams conv weights and biases for one or all layers out of a synchronous
// weight ROM and presents them as tagged, back-pressured writes.
//   clk, reset        : clock, async active-low reset
//   start             : one-cycle load request (ignored while busy)
//   mode_single       : 1 = load layer_sel only, 0 = load all layers
//   layer_sel         : layer for single-layer loads
//   busy, done        : load in progress / one-cycle completion pulse
//   cfg_err           : one-cycle pulse for a single-layer start on a bad layer
//   checksum          : mod-2^16 sum of accepted wr_data since the last start
//   bus (master)      : ROM read port and tagged write port
// -----------------------------------------------------------------------------
module weight_stream_loader
    import weight_loader_pkg::*;
#(
    parameter int                      DATA_WIDTH   = 8,
    parameter int                      ADDR_WIDTH   = 16,
    parameter int                      NUM_LAYERS   = 6,
    parameter logic [8*NUM_LAYERS-1:0] LAYER_IN_CH  = {8'd9, 8'd9, 8'd9, 8'd9, 8'd3, 8'd3},
    parameter logic [8*NUM_LAYERS-1:0] LAYER_OUT_CH = {8'd3, 8'd9, 8'd9, 8'd9, 8'd9, 8'd12},
    parameter int                      ROM_LATENCY  = 2,
    parameter int                      LW           = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode_single,
    input  logic [LW-1:0] layer_sel,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [15:0]   checksum,
    weight_stream_loader_if.master bus
);
    localparam int            FIFO_DEPTH = ROM_LATENCY + 2;
    localparam int            CW         = $clog2(FIFO_DEPTH + 1);
    localparam int            FIFO_W     = $bits(wl_tag_t) + DATA_WIDTH;
    localparam logic [PW-1:0] IN_PACKED  = PW'(LAYER_IN_CH);
    localparam logic [PW-1:0] OUT_PACKED = PW'(LAYER_OUT_CH);

    wl_state_t             state_reg;
    logic                  busy_reg, done_reg, cfg_err_reg;
    logic                  rom_en_reg;
    logic [ADDR_WIDTH-1:0] rom_addr_reg;
    wl_tag_t               tag_reg;
    logic [15:0]           checksum_reg;

    // Address generator: describes the next read to issue.
    logic [LW-1:0]         layer_reg, last_layer_reg;
    logic [7:0]            o_reg, i_reg;
    logic [3:0]            t_reg;
    logic                  bias_reg;
    logic [ADDR_WIDTH-1:0] addr_cnt_reg;

    // Return path.
    logic [ROM_LATENCY-1:0] v_pipe;
    wl_tag_t                tag_pipe [ROM_LATENCY];
    logic [FIFO_W-1:0]      head_word;
    logic                   fifo_valid;
    logic [CW-1:0]          fifo_count;
    wl_tag_t                head_tag;
    logic [DATA_WIDTH-1:0]  head_data;

    logic                  pop, issue, sel_bad;
    logic [CW-1:0]         committed, after_pop;
    logic [7:0]            in_last, out_last;
    logic [ADDR_WIDTH-1:0] start_base;

    always_comb begin
        pop = fifo_valid & bus.wr_ready;
        // Every read issued but not yet written occupies a FIFO slot-to-be:
        // the read on the ROM port this cycle, the ones in the latency pipe
        // and the words already sitting in the FIFO.
        committed = CW'(rom_en_reg) + fifo_count;
        for (int s = 0; s < ROM_LATENCY; s++) begin
            committed = committed + CW'(v_pipe[s]);
        end
        after_pop  = committed - CW'(pop);
        issue      = (state_reg == S_ISSUE) && (after_pop < CW'(FIFO_DEPTH));
        in_last    = 8'(layer_in(int'(layer_reg), IN_PACKED) - 1);
        out_last   = 8'(layer_out(int'(layer_reg), OUT_PACKED) - 1);
        sel_bad    = mode_single && (int'(layer_sel) >= NUM_LAYERS);
        start_base = mode_single ? ADDR_WIDTH'(layer_base(int'(layer_sel), IN_PACKED, OUT_PACKED))
                                 : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
            rom_en_reg     <= 1'b0;
            rom_addr_reg   <= '0;
            tag_reg        <= '0;
            checksum_reg   <= '0;
            layer_reg      <= '0;
            last_layer_reg <= '0;
            o_reg          <= '0;
            i_reg          <= '0;
            t_reg          <= '0;
            bias_reg       <= 1'b0;
            addr_cnt_reg   <= '0;
        end else begin
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
            rom_en_reg  <= 1'b0;
            if (pop) checksum_reg <= checksum_reg + 16'(head_data);

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (sel_bad) begin
                            cfg_err_reg <= 1'b1;
                        end else begin
                            state_reg      <= S_ISSUE;
                            busy_reg       <= 1'b1;
                            checksum_reg   <= '0;
                            layer_reg      <= mode_single ? layer_sel : '0;
                            last_layer_reg <= mode_single ? layer_sel : LW'(NUM_LAYERS - 1);
                            o_reg          <= '0;
                            i_reg          <= '0;
                            t_reg          <= '0;
                            bias_reg       <= 1'b0;
                            addr_cnt_reg   <= start_base;
                        end
                    end
                end

                S_ISSUE: begin
                    if (issue) begin
                        rom_en_reg   <= 1'b1;
                        rom_addr_reg <= addr_cnt_reg;
                        tag_reg      <= '{is_bias: bias_reg, layer: 3'(layer_reg),
                                          out_ch: o_reg, in_ch: i_reg, tap: t_reg};
                        // The ROM layout follows the stepping order, so the
                        // address is a plain counter.
                        addr_cnt_reg <= addr_cnt_reg + 1'b1;
                        if (!bias_reg) begin
                            if (t_reg != 4'd8) begin
                                t_reg <= t_reg + 1'b1;
                            end else begin
                                t_reg <= '0;
                                if (i_reg != in_last) begin
                                    i_reg <= i_reg + 1'b1;
                                end else begin
                                    i_reg <= '0;
                                    if (o_reg != out_last) begin
                                        o_reg <= o_reg + 1'b1;
                                    end else begin
                                        o_reg    <= '0;
                                        bias_reg <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            if (o_reg != out_last) begin
                                o_reg <= o_reg + 1'b1;
                            end else begin
                                o_reg    <= '0;
                                bias_reg <= 1'b0;
                                if (layer_reg == last_layer_reg) state_reg <= S_DRAIN;
                                else                             layer_reg <= layer_reg + 1'b1;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    // Finishes on the cycle the final word is accepted.
                    if (after_pop == '0) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Valid bits follow each read through the ROM latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_pipe <= '0;
        end else begin
            v_pipe[0] <= rom_en_reg;
            for (int s = 1; s < ROM_LATENCY; s++) v_pipe[s] <= v_pipe[s-1];
        end
    end

    // Tags only matter where the matching valid bit is set.
    always_ff @(posedge clk) begin
        tag_pipe[0] <= tag_reg;
        for (int s = 1; s < ROM_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end

    wl_return_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (v_pipe[ROM_LATENCY-1]),
        .push_data  ({tag_pipe[ROM_LATENCY-1], bus.rom_data}),
        .pop        (pop),
        .head_data  (head_word),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

    assign head_tag  = wl_tag_t'(head_word[FIFO_W-1:DATA_WIDTH]);
    assign head_data = head_word[DATA_WIDTH-1:0];

    assign bus.rom_en     = rom_en_reg;
    assign bus.rom_addr   = rom_addr_reg;
    assign bus.wr_valid   = fifo_valid;
    assign bus.wr_is_bias = head_tag.is_bias;
    assign bus.wr_layer   = LW'(head_tag.layer);
    assign bus.wr_out_ch  = head_tag.out_ch;
    assign bus.wr_in_ch   = head_tag.in_ch;
    assign bus.wr_tap     = head_tag.tap;
    assign bus.wr_data    = head_data;

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign cfg_err  = cfg_err_reg;
    assign checksum = checksum_reg;
endmodule

// File: doc/weight_stream_loader.md
Name: weight_stream_loader

Overview:
Parametrised successor to the fixed-size CNN weight loader. It streams per-layer conv weights and biases from a synchronous weight ROM and presents them as tagged writes to the layer weight RAMs. Layer count, channel counts per layer and ROM read latency are set by parameters, and the write port applies back-pressure. It sits between the weight ROM and the superresolution conv layers, and supports a full reload or a reload of a single layer.

Parameters:
DATA_WIDTH, 8, weight/bias word width
ADDR_WIDTH, 16, ROM address width
NUM_LAYERS, 6, number of conv layers (upsample + conv1..conv5)
LAYER_IN_CH, {8'd9,8'd9,8'd9,8'd9,8'd3,8'd3}, packed 8 bits per layer; layer k at [8k+7:8k]
LAYER_OUT_CH, {8'd3,8'd9,8'd9,8'd9,8'd9,8'd12}, packed 8 bits per layer; same layout
ROM_LATENCY, 2, cycles from rom_en/rom_addr to valid rom_data (1..4)
LW, 3, width of layer index

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle load request
mode_single  in  1  sampled at start: 1 = load layer_sel only, 0 = load all layers
layer_sel  in  LW  layer to load when mode_single=1
busy  out  1  load in progress
done  out  1  one-cycle pulse after the last write is accepted
cfg_err  out  1  one-cycle pulse on start with layer_sel>=NUM_LAYERS in single mode
rom_en  out  1  ROM read strobe
rom_addr  out  ADDR_WIDTH  ROM read address
rom_data  in  DATA_WIDTH  ROM read data, valid ROM_LATENCY cycles after rom_en
wr_valid  out  1  write valid
wr_ready  in  1  write accept
wr_is_bias  out  1  1 = bias word, 0 = weight word
wr_layer  out  LW  destination layer
wr_out_ch  out  8  output channel
wr_in_ch  out  8  input channel; 0 for biases
wr_tap  out  4  kernel tap 0..8; 0 for biases
wr_data  out  DATA_WIDTH  word
checksum  out  16  running mod-2^16 sum of accepted wr_data; cleared on accepted start

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. busy, done, cfg_err, rom_en and wr_valid are 0; rom_addr and checksum are 0; FIFO and in-flight pipeline are flushed. Reset mid-load abandons the load with no partial done.
- ROM layout is contiguous per layer, in layer order. Layer k has IN*OUT*9 weights then OUT biases.
  - Weight address = base_k + (o*IN+i)*9 + t.
  - Bias address = base_k + IN*OUT*9 + o.
  - Defaults give bases 0, 336, 588, 1326, 2064, 2802; 3048 words total.
- FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
  - IDLE: start with valid config latches mode/layer, clears checksum, sets busy next cycle, goes to ISSUE. An invalid single-layer start pulses cfg_err and stays IDLE. start while busy is ignored.
  - ISSUE: raise rom_en only when (in-flight + FIFO occupancy) < FIFO_DEPTH, with FIFO_DEPTH = ROM_LATENCY+2. The address generator steps t, then i, then o, then the bias phase, then the next layer. After the last address of the last selected layer, go to DRAIN.
  - DRAIN: wait until in-flight reads and the FIFO are both empty. Then pulse done, clear busy in the same cycle, and return to IDLE.
- Return path:
  - A ROM_LATENCY-deep valid/tag shift register carries the tag {is_bias, layer, o, i, t} alongside each read.
  - Returned data plus tag are pushed into the FIFO. The FIFO head drives the wr_* outputs.
  - A word is transferred when wr_valid & wr_ready. While wr_valid=1 the wr_* outputs stay stable until accepted.
  - The credit rule above guarantees the FIFO never overflows.
- Throughput: 1 word/cycle when wr_ready=1 throughout. The first wr_valid occurs ROM_LATENCY+1 cycles after the first rom_en.
- checksum adds wr_data (zero-extended) on each accepted transfer and wraps mod 2^16. It holds its value after done.

Decomposition:
- Package weight_loader_pkg holds:
  - state encoding;
  - functions layer_in(k), layer_out(k), layer_words(k) and layer_base(k), evaluated on the packed parameters;
  - TOTAL_WORDS;
  - the tag struct.
- Sub-module wl_return_fifo: synchronous FIFO for data plus tag, parametrised by width and depth, with occupancy output; async active-low reset.

Test Plan:
1. Full load, wr_ready=1, ROM data = addr[7:0], ROM_LATENCY=2 -> 3048 writes, no gaps; first write layer0/o0/i0/t0 from addr 0; last write bias layer5 o2 from addr 3047; checksum=0xE32C; single done pulse.
2. Single-layer load, layer_sel=2 -> 738 writes from rom_addr 588..1325; first 729 have wr_is_bias=0, last 9 are biases o=0..8.
3. Random wr_ready (50%, including 20-cycle stalls) -> identical write sequence and checksum to scenario 1; wr_* stable while stalled; FIFO occupancy never exceeds 4.
4. start pulses while busy, and start with mode_single=1, layer_sel=6 -> busy run unaffected; cfg_err pulses one cycle; no writes from the invalid start.
5. reset asserted mid-load (after 1000 writes), then released and start -> all outputs at reset values immediately; the new load restarts from addr 0 and completes with 3048 writes.
6. Rebuild with ROM_LATENCY=1 and 4 -> scenario 1 results unchanged; first wr_valid at ROM_LATENCY+1 cycles after the first rom_en.
